// File: rtl/hdmi_video_timing.sv
// Raster timing generator for an HDMI/DVI transmitter: pixel/line counters with
// registered active, sync, position and start-of-line/frame strobes.
module hdmi_video_timing #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  output logic        active,
  output logic        h_sync,
  output logic        v_sync,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        line_start,
  output logic        frame_start
);

  localparam int unsigned CW       = 12;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_ACTIVE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  // Reject degenerate or oversized rasters at elaboration time.
  if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_param
    $error("hdmi_video_timing: every timing parameter must be at least 1");
  end
  if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_bad_total
    $error("hdmi_video_timing: H_TOTAL and V_TOTAL must not exceed 4095");
  end

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          h_last_c;
  logic          v_last_c;

  assign h_last_c = (h_cnt == CW'(H_TOTAL - 1));
  assign v_last_c = (v_cnt == CW'(V_TOTAL - 1));

  // Outputs are decoded from the pre-increment counters, so they lag them by one clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      active      <= 1'b0;
      h_sync      <= ~H_SYNC_POL;
      v_sync      <= ~V_SYNC_POL;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (ce) begin
        active      <= (h_cnt < CW'(H_ACTIVE)) && (v_cnt < CW'(V_ACTIVE));
        h_sync      <= (h_cnt >= CW'(HS_START) && h_cnt < CW'(HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
        v_sync      <= (v_cnt >= CW'(VS_START) && v_cnt < CW'(VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
        x           <= h_cnt;
        y           <= v_cnt;
        line_start  <= (h_cnt == '0);
        frame_start <= (h_cnt == '0) && (v_cnt == '0);
        if (h_last_c) begin
          h_cnt <= '0;
          v_cnt <= v_last_c ? '0 : v_cnt + CW'(1);
        end else begin
          h_cnt <= h_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Scoreboard bench for hdmi_video_timing: default, small and tiny rasters run in
// lockstep from shared reset/ce, plus directed interval and run-length checks.
module tb_hdmi_video_timing;

  typedef struct packed {
    logic        act;
    logic        hs;
    logic        vs;
    logic [11:0] x;
    logic [11:0] y;
    logic        ls;
    logic        fs;
  } out_t;
  typedef out_t [2:0] trio_t;

  // Instance 0: 640x480 defaults; 1: 15x13 raster; 2: all-ones 4x4 raster.
  localparam int HA[3] = '{640, 8, 1};
  localparam int HF[3] = '{16, 2, 1};
  localparam int HS[3] = '{96, 3, 1};
  localparam int HB[3] = '{48, 2, 1};
  localparam int VA[3] = '{480, 6, 1};
  localparam int VF[3] = '{10, 2, 1};
  localparam int VS[3] = '{2, 2, 1};
  localparam int VB[3] = '{33, 3, 1};
  localparam bit HP[3] = '{1'b0, 1'b1, 1'b1};
  localparam bit VP[3] = '{1'b0, 1'b0, 1'b1};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic        a[3];
  logic        hs[3];
  logic        vs[3];
  logic [11:0] xw[3];
  logic [11:0] yw[3];
  logic        ls[3];
  logic        fs[3];
  trio_t       got;

  int errors = 0;
  int checks = 0;

  trio_t sb[$];
  int    hc[3] = '{0, 0, 0};
  int    vc[3] = '{0, 0, 0};
  out_t  prev[3];

  int cyc = 0;
  int last_fs[3] = '{-1, -1, -1};
  int fs_gap[3] = '{0, 0, 0};
  int vs_acc[3] = '{0, 0, 0};
  int vs_frame[3] = '{0, 0, 0};
  int last_ls = -1;
  int ls_gap = 0;
  int act_line0 = 0;
  int hs_front0 = 0;
  int hs_pulse0 = 0;
  int hs_back0 = 0;

  always #5 clk = ~clk;

  hdmi_video_timing u_dut0 (
    .clk(clk), .reset(reset), .ce(ce), .active(a[0]), .h_sync(hs[0]), .v_sync(vs[0]),
    .x(xw[0]), .y(yw[0]), .line_start(ls[0]), .frame_start(fs[0])
  );

  hdmi_video_timing #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0)
  ) u_dut1 (
    .clk(clk), .reset(reset), .ce(ce), .active(a[1]), .h_sync(hs[1]), .v_sync(vs[1]),
    .x(xw[1]), .y(yw[1]), .line_start(ls[1]), .frame_start(fs[1])
  );

  hdmi_video_timing #(
    .H_ACTIVE(1), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_ACTIVE(1), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) u_dut2 (
    .clk(clk), .reset(reset), .ce(ce), .active(a[2]), .h_sync(hs[2]), .v_sync(vs[2]),
    .x(xw[2]), .y(yw[2]), .line_start(ls[2]), .frame_start(fs[2])
  );

  assign got = {a[2], hs[2], vs[2], xw[2], yw[2], ls[2], fs[2],
                a[1], hs[1], vs[1], xw[1], yw[1], ls[1], fs[1],
                a[0], hs[0], vs[0], xw[0], yw[0], ls[0], fs[0]};

  // Expected outputs after the coming edge, for the inputs just driven.
  task automatic model_push();
    trio_t e;
    int ht;
    int vt;
    for (int i = 0; i < 3; i++) begin
      ht = HA[i] + HF[i] + HS[i] + HB[i];
      vt = VA[i] + VF[i] + VS[i] + VB[i];
      if (reset) begin
        hc[i] = 0;
        vc[i] = 0;
        e[i] = '0;
        e[i].hs = !HP[i];
        e[i].vs = !VP[i];
      end else if (ce) begin
        e[i].act = (hc[i] < HA[i]) && (vc[i] < VA[i]);
        e[i].hs = (hc[i] >= HA[i] + HF[i] && hc[i] < HA[i] + HF[i] + HS[i]) ? HP[i] : !HP[i];
        e[i].vs = (vc[i] >= VA[i] + VF[i] && vc[i] < VA[i] + VF[i] + VS[i]) ? VP[i] : !VP[i];
        e[i].x = 12'(hc[i]);
        e[i].y = 12'(vc[i]);
        e[i].ls = (hc[i] == 0);
        e[i].fs = (hc[i] == 0) && (vc[i] == 0);
        hc[i]++;
        if (hc[i] == ht) begin
          hc[i] = 0;
          vc[i]++;
          if (vc[i] == vt) vc[i] = 0;
        end
      end else begin
        e[i] = prev[i];
        e[i].ls = 1'b0;
        e[i].fs = 1'b0;
      end
      prev[i] = e[i];
    end
    sb.push_back(e);
  endtask

  task automatic step(input logic r, input logic c);
    @(negedge clk);
    reset = r;
    ce = c;
    model_push();
  endtask

  task automatic chk(input string name, input int act_v, input int exp_v);
    checks++;
    if (act_v != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act_v, exp_v);
    end
  endtask

  // Monitor: pops one expectation per clk and gathers interval / run-length stats.
  initial begin
    trio_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        cyc++;
        for (int i = 0; i < 3; i++) begin
          checks++;
          if (got[i] !== e[i]) begin
            errors++;
            $display("FAIL sb_inst%0d cyc=%0d got a=%0b hs=%0b vs=%0b x=%0d y=%0d ls=%0b fs=%0b exp a=%0b hs=%0b vs=%0b x=%0d y=%0d ls=%0b fs=%0b",
                     i, cyc, got[i].act, got[i].hs, got[i].vs, got[i].x, got[i].y, got[i].ls, got[i].fs,
                     e[i].act, e[i].hs, e[i].vs, e[i].x, e[i].y, e[i].ls, e[i].fs);
          end
          if (got[i].fs === 1'b1) begin
            if (last_fs[i] >= 0) fs_gap[i] = cyc - last_fs[i];
            last_fs[i] = cyc;
            vs_frame[i] = vs_acc[i];
            vs_acc[i] = 0;
          end
          if (got[i].vs === VP[i]) vs_acc[i]++;
        end
        if (got[0].ls === 1'b1) begin
          if (last_ls >= 0) ls_gap = cyc - last_ls;
          last_ls = cyc;
        end
        if (got[0].y == 12'd0) begin
          if (got[0].act === 1'b1) act_line0++;
          if (got[0].x >= 12'd640 && got[0].x < 12'd656 && got[0].hs === 1'b1) hs_front0++;
          if (got[0].hs === 1'b0) hs_pulse0++;
          if (got[0].x >= 12'd752 && got[0].hs === 1'b1) hs_back0++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset holds regardless of ce.
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    @(posedge clk); #1;
    chk("rst_active", int'(got[0].act), 0);
    chk("rst_hsync", int'(got[0].hs), 1);
    chk("rst_vsync", int'(got[0].vs), 1);
    chk("rst_x", int'(got[0].x), 0);
    chk("rst_tiny_hsync", int'(got[2].hs), 0);

    // Release with ce=1: first output is the frame origin.
    step(1'b0, 1'b1);
    @(posedge clk); #1;
    chk("first_active", int'(got[0].act), 1);
    chk("first_fs", int'(got[0].fs), 1);
    chk("first_ls", int'(got[0].ls), 1);
    chk("first_xy", int'({got[0].x, got[0].y}), 0);
    for (int i = 0; i < 1999; i++) step(1'b0, 1'b1);
    @(posedge clk); #2;
    chk("line0_active_clks", act_line0, 640);
    chk("line0_hs_front_clks", hs_front0, 16);
    chk("line0_hs_pulse_clks", hs_pulse0, 96);
    chk("line0_hs_back_clks", hs_back0, 48);
    chk("ls_period", ls_gap, 800);
    chk("small_frame_period", fs_gap[1], 195);
    chk("small_vsync_clks", vs_frame[1], 30);
    chk("tiny_frame_period", fs_gap[2], 16);
    chk("tiny_vsync_clks", vs_frame[2], 4);

    // ce toggling 1,0: periods double, strobes stay single-cycle.
    for (int i = 0; i < 4000; i++) step(1'b0, (i % 2 == 0) ? 1'b1 : 1'b0);
    @(posedge clk); #2;
    chk("ce_ls_period", ls_gap, 1600);
    chk("ce_small_frame_period", fs_gap[1], 390);
    chk("ce_small_vsync_clks", vs_frame[1], 60);
    chk("ce_tiny_frame_period", fs_gap[2], 32);

    // Mid-line reset at x=300 discards the partial frame.
    n = 0;
    do begin
      step(1'b0, 1'b1);
      @(posedge clk); #1;
      n++;
    end while (got[0].x != 12'd300 && n < 1000);
    chk("reach_x300", int'(got[0].x), 300);
    step(1'b1, 1'b1);
    @(posedge clk); #1;
    chk("midrst_active", int'(got[0].act), 0);
    chk("midrst_sync", int'({got[0].hs, got[0].vs}), 3);
    chk("midrst_xy", int'({got[0].x, got[0].y}), 0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    @(posedge clk); #1;
    chk("restart_fs", int'(got[0].fs), 1);
    chk("restart_active", int'(got[0].act), 1);
    chk("restart_small_fs", int'(got[1].fs), 1);
    chk("restart_tiny_fs", int'(got[2].fs), 1);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1);
    @(posedge clk); #2;
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hdmi_video_timing.md
HDMI_VIDEO_TIMING -- requirements
Module: hdmi_video_timing

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FRONT, default 16, horizontal front-porch pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync-pulse pixels.
REQ-004 Parameter H_BACK, default 48, horizontal back-porch pixels.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FRONT, default 10, vertical front-porch lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync-pulse lines.
REQ-008 Parameter V_BACK, default 33, vertical back-porch lines.
REQ-009 Parameter H_SYNC_POL, default 0, level of h_sync during the pulse (0 = active-low).
REQ-010 Parameter V_SYNC_POL, default 0, level of v_sync during the pulse.
REQ-011 clk  input  1  pixel clock; one clock only, all logic on its rising edge.
REQ-012 reset  input  1  synchronous, active-high reset.
REQ-013 ce  input  1  pixel clock enable; the timing advances only on cycles with ce=1.
REQ-014 active  output  1  high while the current pixel is visible; feeds the TMDS encoder's active input.
REQ-015 h_sync  output  1  horizontal sync at the H_SYNC_POL level during the pulse.
REQ-016 v_sync  output  1  vertical sync at the V_SYNC_POL level during the pulse.
REQ-017 x  output  12  horizontal pixel position of the current output cycle.
REQ-018 y  output  12  vertical line position of the current output cycle.
REQ-019 line_start  output  1  single-cycle pulse marking pixel x=0.
REQ-020 frame_start  output  1  single-cycle pulse marking x=0, y=0.

Function
REQ-021 Internal counters: h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1, 12 bits unsigned.
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK, 800 by default.
- V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK, 525 by default.
REQ-022 On a ce=1 cycle, h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
REQ-023 v_cnt wraps to 0 when it increments from V_TOTAL-1, which occurs only together with the h_cnt wrap.
REQ-024 On ce=0 cycles, the counters and all outputs hold their values; line_start and frame_start are forced to 0 on those cycles.
REQ-025 All outputs are registered and reflect the counter values from before that cycle's increment; latency from counter state to outputs is exactly 1 clk.
REQ-026 active = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
REQ-027 h_sync equals H_SYNC_POL when H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC, and ~H_SYNC_POL otherwise.
REQ-028 v_sync equals V_SYNC_POL when V_ACTIVE+V_FRONT <= v_cnt < V_ACTIVE+V_FRONT+V_SYNC, and ~V_SYNC_POL otherwise; v_sync changes only at the h_cnt wrap.
REQ-029 x = h_cnt and y = v_cnt, output on every ce cycle including blanking.
REQ-030 line_start = 1 when h_cnt = 0; frame_start = 1 when h_cnt = 0 and v_cnt = 0.
REQ-031 Sync outputs are independent of active, so the downstream encoder sees syncs only while active = 0.
REQ-032 Each of the eight timing parameters is at least 1, and H_TOTAL and V_TOTAL are each at most 4095; violation is a compile-time error.

Reset
REQ-033 While reset = 1, regardless of ce:
- h_cnt = 0, v_cnt = 0.
- active = 0, x = 0, y = 0.
- h_sync = ~H_SYNC_POL, v_sync = ~V_SYNC_POL.
- line_start = 0, frame_start = 0.
REQ-034 Reset asserted mid-frame takes effect on the next clk edge and discards the partial frame.
REQ-035 On the first ce=1 cycle after reset deasserts, outputs show x=0, y=0, active=1, line_start=1, frame_start=1.

Verification
REQ-036 Reset release with ce held at 1, default parameters:
- the first output cycle has x=0, y=0, active=1, frame_start=1.
- the next frame_start arrives exactly 420000 clks later.
REQ-037 One line, default parameters:
- active=1 for 640 clks.
- h_sync=1 for 16 clks, then 0 for 96 clks, then 1 for 48 clks.
- line_start recurs every 800 clks.
REQ-038 Vertical timing, default parameters:
- v_sync=0 exactly while y is 490..491, i.e. for 1600 clks.
- active=0 for every cycle with y >= 480.
REQ-039 ce toggled 1,0,1,0 throughout a frame:
- the frame spans 840000 clks.
- x and y never skip or repeat across ce=1 cycles.
- line_start and frame_start are never high on a ce=0 cycle.
REQ-040 Reset asserted at x=300, y=200:
- the next edge gives active=0, h_sync=1, v_sync=1, x=0, y=0.
- after release, the sequence restarts at frame_start=1.
REQ-041 Tiny parameters (all 1, H_SYNC_POL=1):
- H_TOTAL=4, V_TOTAL=4.
- h_sync=1 only at x=2, v_sync=1 only at y=2.
- active=1 only at (0,0).
- the frame is 16 clks.
